// File: rtl/execute_stage.sv
// execute_stage: forwarding muxes, ALU, flags and E->M register of the 8-bit pipeline.
// EXECUTE_STAGE_MUL_EN adds the iterative shift-add multiplier (MUL, code 1001).
module execute_stage #(
   parameter int          W         = 8,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] RD1E,
   input  logic [W-1:0] RD2E,
   input  logic [W-1:0] ImmE,
   input  logic         ImmSrcE,
   input  logic [3:0]   ALUControlE,
   input  logic         FlagWriteE,
   input  logic         RegWriteAE,
   input  logic         RegWriteBE,
   input  logic         MemtoRegE,
   input  logic [2:0]   WA3E,
   input  logic [2:0]   WA4E,
   input  logic [1:0]   ShowE,
   input  logic [15:0]  InstrE,
   input  logic [1:0]   ForwardAE,
   input  logic [1:0]   ForwardBE,
   input  logic [W-1:0] ResultW,
   output logic         BusyE,
   output logic [3:0]   Flags,
   output logic [W-1:0] ALUResultM,
   output logic [W-1:0] ResultHiM,
   output logic [W-1:0] WriteDataM,
   output logic [2:0]   WA3M,
   output logic [2:0]   WA4M,
   output logic         RegWriteAM,
   output logic         RegWriteBM,
   output logic         MemtoRegM,
   output logic [1:0]   ShowM,
   output logic [15:0]  InstrM
);
   logic           valid, defined, c_n, v_n;
   logic [W-1:0]   src_a, fwd_b, src_b, res;
   logic           start, in_mul, mul_done;
   logic [2*W-1:0] prod;
   logic [2:0]     l_wa3, l_wa4;
   logic           l_rwa, l_rwb, l_mtr, l_fw;
   logic [1:0]     l_show;
   logic [15:0]    l_instr;

   assign valid = InstrE != NOP_INSTR;
   assign src_a = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1E;
   assign fwd_b = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2E;
   assign src_b = ImmSrcE ? ImmE : fwd_b;

   always_comb begin
      res     = src_a;
      c_n     = Flags[1];
      v_n     = Flags[0];
      defined = 1'b1;
      case (ALUControlE)
         4'b0000: begin
            {c_n, res} = {1'b0, src_a} + {1'b0, src_b};
            v_n = (src_a[W-1] == src_b[W-1]) && (res[W-1] != src_a[W-1]);
         end
         4'b0001: begin
            res = src_a - src_b;
            c_n = src_a >= src_b;
            v_n = (src_a[W-1] != src_b[W-1]) && (res[W-1] != src_a[W-1]);
         end
         4'b0010: res = src_a & src_b;
         4'b0011: res = src_a | src_b;
         4'b0100: res = src_a ^ src_b;
         4'b0101: res = ~src_a;
         4'b0110: begin
            res = {src_a[W-2:0], 1'b0};
            c_n = src_a[W-1];
         end
         4'b0111: begin
            res = {1'b0, src_a[W-1:1]};
            c_n = src_a[0];
         end
         4'b1000: res = src_b;
         default: defined = 1'b0;
      endcase
   end

`ifdef EXECUTE_STAGE_MUL_EN
   localparam int CW = $clog2(W);
   typedef enum logic {IDLE, MUL} state_t;
   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   mcand, mplier;
   logic [2*W-1:0] acc;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb state_nx = start ? MUL : mul_done ? IDLE : state;

   // start is gated by rst_n so BusyE stays low while reset is asserted
   always_comb begin
      start = rst_n && state == IDLE && valid && ALUControlE == 4'b1001;
      BusyE = start || (state == MUL && cnt != CW'(W-1));
   end

   assign in_mul   = state == MUL;
   assign mul_done = in_mul && cnt == CW'(W-1);
   assign prod     = acc + (mplier[cnt] ? ({{W{1'b0}}, mcand} << cnt) : '0);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         l_wa3   <= '0;
         l_wa4   <= '0;
         l_rwa   <= 1'b0;
         l_rwb   <= 1'b0;
         l_mtr   <= 1'b0;
         l_fw    <= 1'b0;
         l_show  <= '0;
         l_instr <= NOP_INSTR;
      end else if (start) begin
         cnt     <= '0;
         mcand   <= src_a;
         mplier  <= src_b;
         acc     <= '0;
         l_wa3   <= WA3E;
         l_wa4   <= WA4E;
         l_rwa   <= RegWriteAE;
         l_rwb   <= RegWriteBE;
         l_mtr   <= MemtoRegE;
         l_fw    <= FlagWriteE;
         l_show  <= ShowE;
         l_instr <= InstrE;
      end else if (in_mul) begin
         acc <= prod;
         cnt <= cnt + 1'b1;
      end
`else
   assign start    = 1'b0;
   assign in_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign prod     = '0;
   assign l_wa3    = '0;
   assign l_wa4    = '0;
   assign l_rwa    = 1'b0;
   assign l_rwb    = 1'b0;
   assign l_mtr    = 1'b0;
   assign l_fw     = 1'b0;
   assign l_show   = '0;
   assign l_instr  = NOP_INSTR;
   assign BusyE    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ALUResultM <= '0;
         ResultHiM  <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
         WA4M       <= '0;
         RegWriteAM <= 1'b0;
         RegWriteBM <= 1'b0;
         MemtoRegM  <= 1'b0;
         ShowM      <= '0;
         InstrM     <= NOP_INSTR;
         Flags      <= '0;
      end else if (start || (in_mul && !mul_done)) begin
         ALUResultM <= '0;
         ResultHiM  <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
         WA4M       <= '0;
         RegWriteAM <= 1'b0;
         RegWriteBM <= 1'b0;
         MemtoRegM  <= 1'b0;
         ShowM      <= '0;
         InstrM     <= NOP_INSTR;
      end else if (mul_done) begin
         ALUResultM <= prod[W-1:0];
         ResultHiM  <= prod[2*W-1:W];
         WriteDataM <= '0;
         WA3M       <= l_wa3;
         WA4M       <= l_wa4;
         RegWriteAM <= l_rwa;
         RegWriteBM <= l_rwb;
         MemtoRegM  <= l_mtr;
         ShowM      <= l_show;
         InstrM     <= l_instr;
         if (l_fw) Flags[3:2] <= {prod[2*W-1], prod == '0};
      end else begin
         ALUResultM <= res;
         ResultHiM  <= '0;
         WriteDataM <= fwd_b;
         WA3M       <= WA3E;
         WA4M       <= WA4E;
         RegWriteAM <= RegWriteAE && valid;
         RegWriteBM <= RegWriteBE && valid && ALUControlE != 4'b1001;
         MemtoRegM  <= MemtoRegE && valid;
         ShowM      <= ShowE;
         InstrM     <= InstrE;
         if (FlagWriteE && valid && defined) Flags <= {res[W-1], res == '0, c_n, v_n};
      end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 8-bit pipelined processor; consumes the D->E pipeline register outputs and produces the E->M pipeline register.
- Contains the operand forwarding muxes, the ALU, the architectural flags register, and an iterative 8x8 shift-add multiplier.
- The multiplier writes the low byte through write port A (WA3) and the high byte through write port B (WA4).
- BusyE drives the hazard unit, which stalls F/D and flushes E while a multiply is in progress.

Parameters:
- W, 8, datapath width; the multiplier runs W iterations. Only W=8 is verified.
- NOP_INSTR, 16'h0000, instruction word that marks a bubble.

Ports:
- clk in 1 system clock
- rst_n in 1 asynchronous active-low reset
- RD1E, RD2E in W register operands
- ImmE in W immediate
- ImmSrcE in 1 1 = SrcB from ImmE
- ALUControlE in 4 operation
- FlagWriteE, RegWriteAE, RegWriteBE, MemtoRegE in 1 control
- WA3E, WA4E in 3 destination registers
- ShowE in 2 display select
- InstrE in 16 instruction; NOP_INSTR = bubble
- ForwardAE, ForwardBE in 2 forward select: 00 register, 01 ResultW, 10 ALUResultM
- ResultW in W writeback value
- BusyE out 1 multiplier busy, to hazard unit
- Flags out 4 {N,Z,C,V}, to decode
- ALUResultM, ResultHiM, WriteDataM out W
- WA3M, WA4M out 3
- RegWriteAM, RegWriteBM, MemtoRegM out 1
- ShowM out 2
- InstrM out 16

Behaviour:
- Reset (async, rst_n=0): all M outputs 0, InstrM = NOP_INSTR, Flags = 0, FSM = IDLE, BusyE = 0.
- Reset mid-multiply aborts the operation with no writeback.
- Bubble: valid = (InstrE != NOP_INSTR). When valid = 0:
  - RegWriteAM, RegWriteBM and MemtoRegM load 0.
  - Flags are held.
  - This is required because a flush zeroes only the instruction field, not the other controls.
- Operand selection:
  - SrcA = forward(ForwardAE, RD1E).
  - fwdB = forward(ForwardBE, RD2E).
  - SrcB = ImmSrcE ? ImmE : fwdB.
  - WriteDataM = fwdB.
  - Forward select 11 behaves as 00.
- ALU operations, all single-cycle with the M register loaded at the next edge. "C,V kept" means C and V hold their previous values.
  - 0000 ADD: A+B. C = carry out, V = signed overflow.
  - 0001 SUB: A-B. C = 1 when A >= B unsigned, V = signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR: C,V kept.
  - 0101 NOT A: C,V kept.
  - 0110 SHL by 1: C = A[7], V kept.
  - 0111 SHR logical by 1: C = A[0], V kept.
  - 1000 MOV B: C,V kept.
  - 1001 MUL: see the multiplier section below.
  - Any other code: result = SrcA, flags held regardless of FlagWriteE.
- Flag rules:
  - N = result[W-1] and Z = (result == 0) for every defined operation.
  - Flags update at the edge only when FlagWriteE & valid.
- Non-MUL writeback: ResultHiM = 0, RegWriteBM = RegWriteBE & valid.
- Multiplier FSM, states IDLE and MUL with a 3-bit counter cnt:
  - Start (cycle N): IDLE & valid & ALUControlE = 1001.
  - At the start edge: latch SrcA and SrcB internally, clear the accumulator, set cnt = 0, go to MUL, and load a bubble into the M register.
  - In MUL, each cycle: if multiplier bit cnt is 1, add multiplicand << cnt into the 16-bit accumulator; then cnt++.
  - BusyE = start | (MUL & cnt != 7), combinational. BusyE is high in cycles N..N+7 and low in cycle N+8.
  - Edge ending cycle N+8 (cnt = 7): return to IDLE and load the M register with:
    - ALUResultM = product[7:0], ResultHiM = product[15:8]
    - WA3M/WA4M and the control outputs as latched at start, InstrM = MUL instruction
  - Flags for MUL (if FlagWriteE was set at start): N = product[15], Z = (product == 0), C,V kept.
  - While in MUL, inputs are ignored; E holds bubbles because the hazard unit flushes E.
  - An instruction that reaches E in cycle N+8 is processed normally next cycle.

Optional Feature:
- Macro: EXECUTE_STAGE_MUL_EN.
- Defined: multiplier present, behaviour as above.
- Undefined:
  - No FSM; BusyE tied 0.
  - Code 1001 behaves as an undefined operation (result = SrcA, flags held).
  - RegWriteBM is forced to 0 for 1001.

Test Plan:
- Reset: hold rst_n=0, drive random inputs -> all outputs 0, InstrM = 0000, BusyE = 0; after release the first ADD executes normally.
- ADD: 8'h7F + 8'h01, FlagWriteE=1 -> ALUResultM = 8'h80, Flags = {1,0,0,1}. SUB: 8'h05 - 8'h05 -> 8'h00, Flags = {0,1,1,0}.
- Forwarding: ForwardAE=10 with ALUResultM=8'h22, ForwardBE=01 with ResultW=8'h11, ADD -> 8'h33. With ImmSrcE=1, ImmE=8'h04 -> ALUResult = 8'h26 and WriteDataM = 8'h11.
- Bubble: InstrE = 0000 with RegWriteAE=1 and FlagWriteE=1 -> RegWriteAM = 0, Flags unchanged.
- MUL: 8'hFF * 8'hFF at cycle N -> BusyE high for exactly 8 cycles; at cycle N+9 ALUResultM = 8'h01, ResultHiM = 8'hFE, RegWriteAM = RegWriteBM = 1, N = 1, Z = 0.
- Reset during MUL: pull rst_n low at cycle N+4 -> BusyE = 0 and no writeback; a following MUL 8'h03 * 8'h00 yields product 0 with Z = 1.
